// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage.
//   RESET_PC_DEFAULT : text-segment base the PC starts from after reset
//   PC_INC           : byte step between sequential instructions
//   fetch_state_t    : fetch FSM state encoding
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam int          PC_INC           = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_select.sv
// Next-PC priority mux and fetch-target legality check.
// Ports:
//   pc            : current PC
//   pc_region     : upper PC bits of the IF/ID entry, used for J-format targets
//   stall         : hold the PC when no redirect is present
//   branch_taken, branch_target, jump, jump_index, jr, jr_target : redirects
//   next_pc       : selected next PC (jr > jump > branch > stall hold > pc+4)
//   illegal       : selected target is misaligned or outside the ROM window
module next_pc_select
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic [DATA_WIDTH-1:0]  pc,
  input  logic [DATA_WIDTH-29:0] pc_region,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [DATA_WIDTH-1:0]  branch_target,
  input  logic                   jump,
  input  logic [25:0]            jump_index,
  input  logic                   jr,
  input  logic [DATA_WIDTH-1:0]  jr_target,
  output logic [DATA_WIDTH-1:0]  next_pc,
  output logic                   illegal
);

  localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(PC_INC * MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] offset;
  logic                  check_en;

  always_comb begin
    next_pc  = pc + DATA_WIDTH'(PC_INC);
    check_en = 1'b1;
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = {pc_region, jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else if (stall) begin
      next_pc  = pc;
      check_en = 1'b0;
    end
  end

  // Unsigned subtraction folds the lower bound into one compare: targets
  // below RESET_PC wrap to huge offsets, as does a pc+4 that wraps past zero.
  assign offset  = next_pc - RESET_PC;
  assign illegal = check_en && ((next_pc[1:0] != 2'b00) || (offset >= SPAN));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM and IF/ID pipeline register.
// Ports:
//   clk, reset        : rising-edge clock, async active-high reset
//   stall, flush      : hazard-unit controls for PC hold / IF/ID squash
//   branch_*, jump*, jr* : redirect requests from ID
//   instruction_in    : combinational ROM data for pc_out
//   pc_out            : current PC, drives ROM address
//   ifid_instruction, ifid_pc_plus4, ifid_valid : IF/ID register
//   fault, fault_pc   : sticky illegal-fetch flag and offending target
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [25:0]           jump_index,
  input  logic                  jr,
  input  logic [DATA_WIDTH-1:0] jr_target,
  input  logic [DATA_WIDTH-1:0] instruction_in,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] ifid_instruction,
  output logic [DATA_WIDTH-1:0] ifid_pc_plus4,
  output logic                  ifid_valid,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] fault_pc
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  illegal;

  next_pc_select #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .RESET_PC    (RESET_PC)
  ) u_next_pc_select (
    .pc           (pc_out),
    .pc_region    (ifid_pc_plus4[DATA_WIDTH-1:28]),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_target    (jr_target),
    .next_pc      (next_pc),
    .illegal      (illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (illegal) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  // PC, IF/ID and fault registers only move in RUN; BOOT and FAULT hold them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out           <= RESET_PC;
      ifid_instruction <= '0;
      ifid_pc_plus4    <= '0;
      ifid_valid       <= 1'b0;
      fault            <= 1'b0;
      fault_pc         <= '0;
    end else if (state_q == RUN) begin
      if (illegal) begin
        fault      <= 1'b1;
        fault_pc   <= next_pc;
        ifid_valid <= 1'b0;
      end else begin
        pc_out <= next_pc;
        if (flush) begin
          ifid_valid       <= 1'b0;
          ifid_instruction <= '0;
        end else if (!stall) begin
          ifid_instruction <= instruction_in;
          ifid_pc_plus4    <= pc_out + DATA_WIDTH'(PC_INC);
          ifid_valid       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, branch_taken, jump, jr;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic [31:0] instruction_in;
  logic [31:0] pc_out, ifid_instruction, ifid_pc_plus4, fault_pc;
  logic        ifid_valid, fault;

  int total = 0;
  int bad   = 0;

  fetch_stage #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(32),
    .RESET_PC    (32'h0040_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump            (jump),
    .jump_index      (jump_index),
    .jr              (jr),
    .jr_target       (jr_target),
    .instruction_in  (instruction_in),
    .pc_out          (pc_out),
    .ifid_instruction(ifid_instruction),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_valid      (ifid_valid),
    .fault           (fault),
    .fault_pc        (fault_pc)
  );

  always #5 clk = ~clk;

  // ROM model: each word's contents are derived from its address.
  assign instruction_in = pc_out ^ MASK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_taken = 0; jump = 0; jr = 0;
    branch_target = '0; jr_target = '0; jump_index = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pc"},     pc_out,                  32'h0040_0000);
    check({tag, "_instr"},  ifid_instruction,        32'h0);
    check({tag, "_plus4"},  ifid_pc_plus4,           32'h0);
    check({tag, "_valid"},  {31'b0, ifid_valid},     32'h0);
    check({tag, "_fault"},  {31'b0, fault},          32'h0);
    check({tag, "_faultpc"}, fault_pc,               32'h0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #12;
    check_reset_values("rst");
    reset = 1'b0;

    // BOOT cycle holds PC and keeps IF/ID empty even with a redirect present
    jr = 1; jr_target = 32'h0040_0050;
    step();
    check("boot_pc",    pc_out,              32'h0040_0000);
    check("boot_valid", {31'b0, ifid_valid}, 32'h0);
    idle_inputs();

    step();
    check("run1_pc",    pc_out,              32'h0040_0004);
    check("run1_plus4", ifid_pc_plus4,       32'h0040_0004);
    check("run1_instr", ifid_instruction,    32'h0040_0000 ^ MASK);
    check("run1_valid", {31'b0, ifid_valid}, 32'h1);
    step();
    check("run2_pc",    pc_out,        32'h0040_0008);
    check("run2_plus4", ifid_pc_plus4, 32'h0040_0008);

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",    pc_out,              32'h0040_0008);
      check("stall_plus4", ifid_pc_plus4,       32'h0040_0008);
      check("stall_instr", ifid_instruction,    32'h0040_0004 ^ MASK);
      check("stall_valid", {31'b0, ifid_valid}, 32'h1);
    end
    stall = 0;
    step();
    check("resume_pc",    pc_out,           32'h0040_000C);
    check("resume_plus4", ifid_pc_plus4,    32'h0040_000C);
    check("resume_instr", ifid_instruction, 32'h0040_0008 ^ MASK);

    branch_taken = 1; branch_target = 32'h0040_0040; flush = 1;
    step();
    check("br_pc",    pc_out,              32'h0040_0040);
    check("br_valid", {31'b0, ifid_valid}, 32'h0);
    check("br_instr", ifid_instruction,    32'h0);
    idle_inputs();
    step();
    check("br_plus4", ifid_pc_plus4,       32'h0040_0044);
    check("br_tinst", ifid_instruction,    32'h0040_0040 ^ MASK);
    check("br_tval",  {31'b0, ifid_valid}, 32'h1);

    // J-format target {0x0, 0x100008, 00} = 0x00400020, with stall overridden
    jump = 1; jump_index = 26'h010_0008; stall = 1;
    step();
    check("j_pc", pc_out, 32'h0040_0020);
    idle_inputs();

    jr = 1; jr_target = 32'h0040_0010;
    jump = 1; jump_index = 26'h010_0008;
    branch_taken = 1; branch_target = 32'h0040_0040;
    step();
    check("prio_pc",    pc_out,        32'h0040_0010);
    check("prio_plus4", ifid_pc_plus4, 32'h0040_0024);
    idle_inputs();

    jr = 1; jr_target = 32'h0040_0012;
    step();
    check("mis_fault",   {31'b0, fault},      32'h1);
    check("mis_faultpc", fault_pc,            32'h0040_0012);
    check("mis_pc",      pc_out,              32'h0040_0010);
    check("mis_valid",   {31'b0, ifid_valid}, 32'h0);
    jr = 0; branch_taken = 1; branch_target = 32'h0040_0040;
    for (int i = 0; i < 2; i++) begin
      step();
      check("frz_pc",      pc_out,              32'h0040_0010);
      check("frz_fault",   {31'b0, fault},      32'h1);
      check("frz_faultpc", fault_pc,            32'h0040_0012);
      check("frz_valid",   {31'b0, ifid_valid}, 32'h0);
      check("frz_plus4",   ifid_pc_plus4,       32'h0040_0024);
    end
    idle_inputs();

    #2 reset = 1'b1;
    #1 check_reset_values("arst1");
    #2 reset = 1'b0;
    step();
    check("boot2_pc", pc_out, 32'h0040_0000);
    step();
    check("run3_pc", pc_out, 32'h0040_0004);

    // Below-window target trips the lower bound
    jr = 1; jr_target = 32'h003F_FFFC;
    step();
    check("low_fault",   {31'b0, fault}, 32'h1);
    check("low_faultpc", fault_pc,       32'h003F_FFFC);
    check("low_pc",      pc_out,         32'h0040_0004);
    idle_inputs();

    #2 reset = 1'b1;
    #1 check_reset_values("arst2");
    #2 reset = 1'b0;
    step();
    step();
    jr = 1; jr_target = 32'h0040_007C;
    step();
    check("last_pc",    pc_out,         32'h0040_007C);
    check("last_fault", {31'b0, fault}, 32'h0);
    idle_inputs();
    step();
    check("end_fault",   {31'b0, fault},      32'h1);
    check("end_faultpc", fault_pc,            32'h0040_0080);
    check("end_pc",      pc_out,              32'h0040_007C);
    check("end_valid",   {31'b0, ifid_valid}, 32'h0);

    #2 reset = 1'b1;
    #1 check_reset_values("arst3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline, directly upstream of the program memory ROM. It owns the program counter and drives the ROM byte address. It selects the next PC from sequential, branch, jump and jump-register sources, and registers the returned instruction into the IF/ID pipeline register. It also supports stall, flush, and a sticky fault on illegal fetch targets.

## Interface
- DATA_WIDTH, 32, width of PC and instruction
- MEMORY_DEPTH, 32, program ROM depth in words; bounds the legal fetch range
- RESET_PC, 32'h0040_0000, text-segment base; PC value after reset
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- stall  input  1  hold PC and IF/ID contents (hazard unit)
- flush  input  1  squash the IF/ID entry being written this edge
- branch_taken  input  1  redirect to branch_target
- branch_target  input  DATA_WIDTH  byte address from ID-stage adder
- jump  input  1  redirect to J-format target
- jump_index  input  26  instr_index field of J/JAL
- jr  input  1  redirect to jr_target
- jr_target  input  DATA_WIDTH  register value for JR/JALR
- instruction_in  input  DATA_WIDTH  combinational ROM read data for pc_out
- pc_out  output  DATA_WIDTH  current PC; drives ROM Address
- ifid_instruction  output  DATA_WIDTH  registered instruction
- ifid_pc_plus4  output  DATA_WIDTH  registered PC+4 of that instruction
- ifid_valid  output  1  IF/ID entry holds a live instruction
- fault  output  1  sticky illegal-fetch flag
- fault_pc  output  DATA_WIDTH  offending target address

## Operation
- FSM states: BOOT, RUN, FAULT. Reset enters BOOT.
- BOOT: lasts one cycle. PC is held at RESET_PC and ifid_valid stays 0. Then go to RUN. Redirect inputs are ignored.
- RUN, next-PC priority: jr > jump > branch_taken > stall (hold) > pc_out+4.
- Jump target: {ifid_pc_plus4[31:28], jump_index, 2'b00}.
- A redirect overrides stall for the PC. It does not by itself clear IF/ID; the hazard unit asserts flush.
- IF/ID update in RUN, evaluated in order:
  - flush: ifid_valid←0, ifid_instruction←0.
  - else stall: hold all IF/ID fields.
  - else: capture instruction_in and pc_out+4, and set ifid_valid←1.
- Legal target:
  - target[1:0]==2'b00, and
  - RESET_PC ≤ target < RESET_PC + 4·MEMORY_DEPTH.
  - The check applies to the selected redirect target and to sequential pc+4.
- Illegal target: go to FAULT.
  - fault←1 and fault_pc←target.
  - PC is held at its old value and ifid_valid←0.
- FAULT: all inputs are ignored and outputs are frozen. Only reset exits.
- Arithmetic is modulo 2^DATA_WIDTH. Wrap of pc+4 is caught by the range check.

## Timing
- Reset values: pc_out=RESET_PC, ifid_instruction=0, ifid_pc_plus4=0, ifid_valid=0, fault=0, fault_pc=0, state=BOOT.
- pc_out is registered. The ROM returns instruction_in in the same cycle, and it is captured at the next rising edge. Fetch latency is 1 cycle.
- First valid IF/ID entry: at the second rising edge after reset deasserts, with instruction RESET_PC, valid=1.
- A redirect sampled at edge N gives pc_out=target after edge N. The target instruction appears in IF/ID after edge N+1.
- Reset asserted mid-operation clears everything immediately, without waiting for clk.
- Simultaneous flush+stall: flush wins for IF/ID. The PC follows the stall/redirect rules.
- Simultaneous jr+jump+branch: jr is taken. The others are dropped without error.

## Structure
- Shared package (mips_pkg): RESET_PC default, fetch FSM state encoding, PC increment constant 4.
- One sub-module: next_pc_select (combinational priority mux plus legality check).
- PC register, FSM and IF/ID register live in fetch_stage.

## Test plan
- Reset, then run freely for 4 cycles:
  - pc_out steps 0x00400000, 0x00400000 (BOOT), 0x00400004, 0x00400008.
  - The IF/ID sequence starts at pc_plus4=0x00400004.
- stall held 3 cycles at pc_out=0x00400008: pc_out and IF/ID are unchanged for 3 edges, then resume at 0x0040000C.
- branch_taken=1, branch_target=0x00400040, flush=1, same cycle:
  - next pc_out=0x00400040 and ifid_valid=0.
  - One edge later ifid_pc_plus4=0x00400044.
- jr=1, jr_target=0x00400010 together with jump=1 and branch_taken=1: pc_out becomes 0x00400010.
- jr_target=0x00400012 (misaligned):
  - fault=1 and fault_pc=0x00400012, PC held, ifid_valid=0.
  - Stays frozen under further inputs until reset.
- Sequential fetch off the ROM end (MEMORY_DEPTH=32, pc_out=0x0040007C): next edge gives fault=1, fault_pc=0x00400080. Asserting reset mid-fault restores all reset values asynchronously.
